alu: RTL and testbench
======================

Name: alu

Overview:
- 32-bit integer ALU with one registered output stage and status flags.
- Sits in the execute stage of the datapath: combinational operation select on operands `a`/`b`, result and flags captured on the next rising clock edge.
- Opcodes 0x0–0x7 are the base set; 0x8–0xF are extended operations.

Parameters:
- WIDTH, 32, operand/result width in bits (shift amount uses the low log2(WIDTH) bits of `b`).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands/opcode valid this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B / shift amount
- op_code  input  4  operation select
- result  output  WIDTH  registered result
- out_valid  output  1  result/flags valid (one cycle after in_valid)
- zero  output  1  registered: result == 0
- negative  output  1  registered: result[WIDTH-1]
- carry  output  1  registered carry/borrow (ADD/SUB only, else 0)
- overflow  output  1  registered signed overflow (ADD/SUB only, else 0)

Behaviour:
- Reset: on a rising edge with rst_n=0, result=0, out_valid=0, zero=1, negative=0, carry=0, overflow=0. Reset overrides in_valid on the same edge.
- Latency is exactly 1 cycle. On a rising edge with in_valid=1, result and all flags are loaded from the current inputs and out_valid=1.
- On a rising edge with in_valid=0, out_valid=0 and result/flags hold their previous values.
- No backpressure. A new operation can be issued every cycle.
- Opcodes (sh = b[4:0] for WIDTH=32):
  - 0x0 ADD: a+b, modulo 2^WIDTH
  - 0x1 SUB: a-b, modulo 2^WIDTH
  - 0x2 AND: a&b
  - 0x3 OR: a|b
  - 0x4 XOR: a^b
  - 0x5 NOT: ~a (b ignored)
  - 0x6 SHL: a<<sh, logical
  - 0x7 SHR: a>>sh, logical, zero fill
  - 0x8 SRA: arithmetic a>>sh, sign fill
  - 0x9 SLT: signed a<b, gives 1, else 0
  - 0xA SLTU: unsigned a<b, gives 1, else 0
  - 0xB NOR: ~(a|b)
  - 0xC NAND: ~(a&b)
  - 0xD XNOR: ~(a^b)
  - 0xE PASSB: b
  - 0xF PASSA: a
- Shift amount uses only b[4:0]; upper bits of b are ignored (so b=32 shifts by 0).
- carry:
  - ADD: carry out of bit WIDTH-1.
  - SUB: borrow, i.e. 1 when a<b unsigned.
  - All other opcodes: 0.
- overflow:
  - ADD: operands have the same sign and the result sign differs.
  - SUB: operand signs differ and the result sign differs from a.
  - All other opcodes: 0.
- zero and negative are computed from the result of the selected operation, for every opcode.
- No X propagation: all 16 opcodes are defined, with no default/latch path.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> result=0, out_valid=0, zero=1, all other flags 0.
- Base set, a=0x0000000A, b=0x00000005, in_valid=1, one opcode per cycle 0x0..0x7 -> result one cycle later: 0x0000000F, 0x00000005, 0x00000000 (zero=1), 0x0000000F, 0x0000000F, 0xFFFFFFF5 (negative=1), 0x00000140, 0x00000000 (zero=1).
- ADD a=0xFFFFFFFF, b=1 -> result=0, zero=1, carry=1, overflow=0. ADD a=0x7FFFFFFF, b=1 -> result=0x80000000, overflow=1, negative=1.
- SUB a=5, b=0xA -> result=0xFFFFFFFB, carry=1, negative=1. SUB a=0x80000000, b=1 -> 0x7FFFFFFF, overflow=1.
- Shifts/compares with a=0x80000000:
  - SRA b=4 -> 0xF8000000.
  - SHR b=4 -> 0x08000000.
  - SHL b=0x21 -> 0x00000000 (sh=1).
  - SLT a vs b=1 -> 1.
  - SLTU a vs b=1 -> 0.
- Valid gating: pulse in_valid for 1 cycle, then hold it low for 3 cycles while inputs change -> out_valid high for exactly 1 cycle, and result holds its value during the idle cycles.

Source files
------------

// File: rtl/alu.sv
// Integer ALU for the execute stage: combinational operation select,
// with the result and status flags captured in one register stage.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op_code,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow
);

  localparam int SH_W = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_NOT   = 4'h5;
  localparam logic [3:0] OP_SHL   = 4'h6;
  localparam logic [3:0] OP_SHR   = 4'h7;
  localparam logic [3:0] OP_SRA   = 4'h8;
  localparam logic [3:0] OP_SLT   = 4'h9;
  localparam logic [3:0] OP_SLTU  = 4'hA;
  localparam logic [3:0] OP_NOR   = 4'hB;
  localparam logic [3:0] OP_NAND  = 4'hC;
  localparam logic [3:0] OP_XNOR  = 4'hD;
  localparam logic [3:0] OP_PASSB = 4'hE;
  localparam logic [3:0] OP_PASSA = 4'hF;

  // Handshake: in_valid qualifies a/b/op_code for one cycle and is always
  // accepted (no ready); out_valid is high exactly one cycle later, and
  // result/flags hold their last loaded value while out_valid is low.

  logic [SH_W-1:0]  sh;
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH-1:0] res_d;
  logic             carry_d;
  logic             overflow_d;
  logic             slt;
  logic             sltu;

  assign sh       = b[SH_W-1:0];
  assign add_full = {1'b0, a} + {1'b0, b};
  // The extra bit of the widened subtraction is the unsigned borrow.
  assign sub_full = {1'b0, a} - {1'b0, b};
  assign slt      = $signed(a) < $signed(b);
  assign sltu     = a < b;

  always_comb begin
    res_d      = '0;
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    case (op_code)
      OP_ADD: begin
        res_d      = add_full[WIDTH-1:0];
        carry_d    = add_full[WIDTH];
        overflow_d = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res_d      = sub_full[WIDTH-1:0];
        carry_d    = sub_full[WIDTH];
        overflow_d = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:   res_d = a & b;
      OP_OR:    res_d = a | b;
      OP_XOR:   res_d = a ^ b;
      OP_NOT:   res_d = ~a;
      OP_SHL:   res_d = a << sh;
      OP_SHR:   res_d = a >> sh;
      OP_SRA:   res_d = $signed(a) >>> sh;
      OP_SLT:   res_d = {{(WIDTH-1){1'b0}}, slt};
      OP_SLTU:  res_d = {{(WIDTH-1){1'b0}}, sltu};
      OP_NOR:   res_d = ~(a | b);
      OP_NAND:  res_d = ~(a & b);
      OP_XNOR:  res_d = ~(a ^ b);
      OP_PASSB: res_d = b;
      OP_PASSA: res_d = a;
      default:  res_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result    <= '0;
      out_valid <= 1'b0;
      zero      <= 1'b1;
      negative  <= 1'b0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result   <= res_d;
        zero     <= (res_d == '0);
        negative <= res_d[WIDTH-1];
        carry    <= carry_d;
        overflow <= overflow_d;
      end
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: a driver pushes hand-computed expectations,
// and a negedge monitor pops and compares whenever out_valid is presented.
module tb_alu;

  localparam int W = 32;
  localparam int EW = W + 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   op_code = '0;
  logic [W-1:0] result;
  logic         out_valid;
  logic         zero;
  logic         negative;
  logic         carry;
  logic         overflow;

  alu #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .a(a),
    .b(b),
    .op_code(op_code),
    .result(result),
    .out_valid(out_valid),
    .zero(zero),
    .negative(negative),
    .carry(carry),
    .overflow(overflow)
  );

  // clock / cycle counter
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: expected {result, zero, negative, carry, overflow}
  logic [EW-1:0] exp_q[$];
  int            tag_q[$];
  logic [EW-1:0] hold_exp = {{W{1'b0}}, 4'b1000};
  int total = 0;
  int bad = 0;

  task automatic send(input logic [3:0] op, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                      input logic [W-1:0] res, input logic z, input logic n,
                      input logic c, input logic v);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    op_code  = op;
    a        = ta;
    b        = tb_;
    exp_q.push_back({res, z, n, c, v});
    tag_q.push_back(cyc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      op_code  = 4'($urandom_range(0, 15));
      a        = $urandom;
      b        = $urandom;
    end
  endtask

  // monitor
  always @(negedge clk) begin
    logic          exp_v;
    logic [EW-1:0] got;
    logic [EW-1:0] e;
    got   = {result, zero, negative, carry, overflow};
    exp_v = (tag_q.size() != 0) && (tag_q[0] + 1 == cyc);
    total++;
    if (out_valid !== exp_v) begin
      bad++;
      $display("FAIL out_valid cyc=%0d got=%b want=%b", cyc, out_valid, exp_v);
    end
    if (exp_v) begin
      e = exp_q.pop_front();
      void'(tag_q.pop_front());
      hold_exp = e;
    end else begin
      e = hold_exp;
    end
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL %s cyc=%0d got res=%h znco=%b want res=%h znco=%b",
               exp_v ? "result" : "hold", cyc, got[EW-1:4], got[3:0], e[EW-1:4], e[3:0]);
    end
  end

  initial begin
    // reset with in_valid high: reset must win
    in_valid = 1'b1;
    op_code  = 4'h0;
    a        = 32'h1;
    b        = 32'h1;
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    idle(1);

    // base set, a=0xA b=0x5
    send(4'h0, 32'h0000000A, 32'h5, 32'h0000000F, 0, 0, 0, 0);
    send(4'h1, 32'h0000000A, 32'h5, 32'h00000005, 0, 0, 0, 0);
    send(4'h2, 32'h0000000A, 32'h5, 32'h00000000, 1, 0, 0, 0);
    send(4'h3, 32'h0000000A, 32'h5, 32'h0000000F, 0, 0, 0, 0);
    send(4'h4, 32'h0000000A, 32'h5, 32'h0000000F, 0, 0, 0, 0);
    send(4'h5, 32'h0000000A, 32'h5, 32'hFFFFFFF5, 0, 1, 0, 0);
    send(4'h6, 32'h0000000A, 32'h5, 32'h00000140, 0, 0, 0, 0);
    send(4'h7, 32'h0000000A, 32'h5, 32'h00000000, 1, 0, 0, 0);

    // add/sub carry and overflow corners
    send(4'h0, 32'hFFFFFFFF, 32'h1, 32'h00000000, 1, 0, 1, 0);
    send(4'h0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 1, 0, 1);
    send(4'h1, 32'h00000005, 32'hA, 32'hFFFFFFFB, 0, 1, 1, 0);
    send(4'h1, 32'h80000000, 32'h1, 32'h7FFFFFFF, 0, 0, 0, 1);
    send(4'h1, 32'h00000003, 32'h3, 32'h00000000, 1, 0, 0, 0);

    // shifts and compares
    send(4'h8, 32'h80000000, 32'h4,  32'hF8000000, 0, 1, 0, 0);
    send(4'h7, 32'h80000000, 32'h4,  32'h08000000, 0, 0, 0, 0);
    send(4'h6, 32'h80000000, 32'h21, 32'h00000000, 1, 0, 0, 0);
    send(4'h8, 32'h80000000, 32'h20, 32'h80000000, 0, 1, 0, 0);
    send(4'h9, 32'h80000000, 32'h1,  32'h00000001, 0, 0, 0, 0);
    send(4'hA, 32'h80000000, 32'h1,  32'h00000000, 1, 0, 0, 0);
    send(4'h9, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1, 0, 0, 0);
    send(4'hA, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 0, 0, 0, 0);

    // remaining extended ops
    send(4'hB, 32'h0F0F0F0F, 32'h00FF00FF, 32'hF000F000, 0, 1, 0, 0);
    send(4'hC, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFFFF, 0, 0, 0, 0);
    send(4'hD, 32'h12345678, 32'h12345678, 32'hFFFFFFFF, 0, 1, 0, 0);
    send(4'hE, 32'h12345678, 32'h80000001, 32'h80000001, 0, 1, 0, 0);
    send(4'hF, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 1, 0, 0, 0);

    // valid gating: single pulse, then idle with changing inputs
    send(4'h4, 32'h000000F0, 32'h0000000F, 32'h000000FF, 0, 0, 0, 0);
    idle(3);
    send(4'h0, 32'h00000001, 32'h00000002, 32'h00000003, 0, 0, 0, 0);
    idle(3);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
